// File: rtl/z80_io_master.sv
// Z80-side I/O bus initiator: queues write/read/intack requests and drives
// Z80-style IORQ_L/M1_L/RD_L/WR_L cycles with registered outputs.
// Optional: define Z80IO_AUTO_INTACK_EN to acknowledge INT_L automatically from IDLE.
module z80_io_master #(
    parameter int unsigned DEPTH           = 4,
    parameter int unsigned STROBE_CYCLES   = 3,
    parameter int unsigned RECOVERY_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [1:0] req_op,
    input  logic [7:0] req_addr,
    input  logic [7:0] req_data,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       rsp_intack,
    output logic [7:0] addr_bus_out,
    output logic [7:0] data_bus_out,
    output logic       data_oe,
    input  logic [7:0] data_bus_in,
    output logic       IORQ_L,
    output logic       M1_L,
    output logic       RD_L,
    output logic       WR_L,
    input  logic       INT_L,
    output logic       int_pending,
    output logic       busy
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [3:0] StrobeLast = 4'(STROBE_CYCLES - 1);
    localparam logic [3:0] RecLast =
        (RECOVERY_CYCLES > 0) ? 4'(RECOVERY_CYCLES - 1) : 4'd0;

    localparam logic [1:0] OpWrite  = 2'd0;
    localparam logic [1:0] OpRead   = 2'd1;
    localparam logic [1:0] OpIntack = 2'd2;

    typedef enum logic [2:0] {
        StIdle, StT1, StT2, StT3, StRec, StInta1, StInta2
    } state_e;

    state_e state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [1:0] op_q, op_d;
    logic [7:0] taddr_q, taddr_d, tdata_q, tdata_d;

    logic       iorq_q, iorq_d, m1_q, m1_d, rd_q, rd_d, wr_q, wr_d, oe_q, oe_d;
    logic [7:0] addr_q, addr_d, dout_q, dout_d;
    logic       rsp_valid_q, rsp_valid_d, rsp_intack_q, rsp_intack_d;
    logic [7:0] rsp_data_q, rsp_data_d;
    logic       int_pending_q;

    // Request FIFO: one extra pointer bit distinguishes full from empty.
    logic [17:0] mem_q [DEPTH];
    logic [AW:0] wptr_q, rptr_q;
    logic        fifo_empty, fifo_full, push, pop;
    logic [1:0]  head_op;
    logic [7:0]  head_addr, head_data;

    assign fifo_empty = (wptr_q == rptr_q);
    assign fifo_full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign push       = req_valid && !fifo_full;
    assign {head_op, head_addr, head_data} = mem_q[rptr_q[AW-1:0]];

`ifdef Z80IO_AUTO_INTACK_EN
    logic auto_start;
    logic ack_block_q, ack_block_d;
`endif

    // FIFO storage writes
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q[AW-1:0]] <= {req_op, req_addr, req_data};
        end
    end

    // FIFO pointers
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (push) wptr_q <= wptr_q + 1'b1;
            if (pop)  rptr_q <= rptr_q + 1'b1;
        end
    end

    // Next-state, transaction latch and registered-output next values
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        taddr_d = taddr_q;
        tdata_d = tdata_q;
        pop     = 1'b0;
`ifdef Z80IO_AUTO_INTACK_EN
        auto_start  = 1'b0;
        ack_block_d = ack_block_q;
`endif

        unique case (state_q)
            StIdle: begin
`ifdef Z80IO_AUTO_INTACK_EN
                if (int_pending_q && !ack_block_q) begin
                    // Interrupt wins over queued work and consumes no FIFO entry.
                    auto_start = 1'b1;
                    op_d       = OpIntack;
                    state_d    = StInta1;
                end else
`endif
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    op_d    = head_op;
                    taddr_d = head_addr;
                    tdata_d = head_data;
                    unique case (head_op)
                        OpWrite, OpRead: state_d = StT1;
                        OpIntack:        state_d = StInta1;
                        default:         state_d = StIdle;  // reserved op dropped
                    endcase
                end
            end
            StT1: begin
                state_d = StT2;
                cnt_d   = StrobeLast;
            end
            StT2: begin
                if (cnt_q == 4'd0) state_d = StT3;
                else               cnt_d   = cnt_q - 4'd1;
            end
            StT3: begin
                if (RECOVERY_CYCLES == 0) begin
                    state_d = StIdle;
                end else begin
                    state_d = StRec;
                    cnt_d   = RecLast;
                end
            end
            StRec: begin
                if (cnt_q == 4'd0) state_d = StIdle;
                else               cnt_d   = cnt_q - 4'd1;
            end
            StInta1: begin
                state_d = StInta2;
                cnt_d   = StrobeLast;
            end
            StInta2: begin
                if (cnt_q == 4'd0) state_d = StT3;
                else               cnt_d   = cnt_q - 4'd1;
            end
            default: state_d = StIdle;
        endcase

`ifdef Z80IO_AUTO_INTACK_EN
        // Re-arm only once the interrupt line has been seen released.
        if (auto_start)          ack_block_d = 1'b1;
        else if (!int_pending_q) ack_block_d = 1'b0;
`endif

        // Outputs are decoded from the next state so they appear registered.
        iorq_d = 1'b1;
        m1_d   = 1'b1;
        rd_d   = 1'b1;
        wr_d   = 1'b1;
        oe_d   = 1'b0;
        addr_d = addr_q;
        dout_d = dout_q;
        unique case (state_d)
            StT1: begin
                addr_d = taddr_d;
                if (op_d == OpWrite) begin
                    dout_d = tdata_d;
                    oe_d   = 1'b1;
                end
            end
            StT2: begin
                iorq_d = 1'b0;
                if (op_d == OpWrite) begin
                    wr_d = 1'b0;
                    oe_d = 1'b1;
                end else begin
                    rd_d = 1'b0;
                end
            end
            StInta1: begin
                addr_d = taddr_d;
                m1_d   = 1'b0;
            end
            StInta2: begin
                m1_d   = 1'b0;
                iorq_d = 1'b0;
            end
            default: ;
        endcase

        // Capture at the edge that ends the last strobe cycle; presented during T3.
        rsp_valid_d  = 1'b0;
        rsp_intack_d = 1'b0;
        rsp_data_d   = rsp_data_q;
        if ((state_q == StT2 && cnt_q == 4'd0 && op_q == OpRead) ||
            (state_q == StInta2 && cnt_q == 4'd0)) begin
            rsp_valid_d  = 1'b1;
            rsp_data_d   = data_bus_in;
            rsp_intack_d = (state_q == StInta2);
        end
    end

    // State, transaction and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            cnt_q         <= 4'd0;
            op_q          <= 2'd0;
            taddr_q       <= 8'd0;
            tdata_q       <= 8'd0;
            iorq_q        <= 1'b1;
            m1_q          <= 1'b1;
            rd_q          <= 1'b1;
            wr_q          <= 1'b1;
            oe_q          <= 1'b0;
            addr_q        <= 8'd0;
            dout_q        <= 8'd0;
            rsp_valid_q   <= 1'b0;
            rsp_intack_q  <= 1'b0;
            rsp_data_q    <= 8'd0;
            int_pending_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            op_q          <= op_d;
            taddr_q       <= taddr_d;
            tdata_q       <= tdata_d;
            iorq_q        <= iorq_d;
            m1_q          <= m1_d;
            rd_q          <= rd_d;
            wr_q          <= wr_d;
            oe_q          <= oe_d;
            addr_q        <= addr_d;
            dout_q        <= dout_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_intack_q  <= rsp_intack_d;
            rsp_data_q    <= rsp_data_d;
            int_pending_q <= ~INT_L;
        end
    end

`ifdef Z80IO_AUTO_INTACK_EN
    // Auto-intack suppression flag
    always_ff @(posedge clk) begin
        if (rst) ack_block_q <= 1'b0;
        else     ack_block_q <= ack_block_d;
    end
`endif

    assign IORQ_L       = iorq_q;
    assign M1_L         = m1_q;
    assign RD_L         = rd_q;
    assign WR_L         = wr_q;
    assign data_oe      = oe_q;
    assign addr_bus_out = addr_q;
    assign data_bus_out = dout_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_data     = rsp_data_q;
    assign rsp_intack   = rsp_intack_q;
    assign int_pending  = int_pending_q;
    assign req_ready    = !fifo_full;
    assign busy         = (state_q != StIdle) || !fifo_empty;

endmodule

// File: tb/tb_z80_io_master.sv
// Self-checking bench for z80_io_master: table-driven single transactions plus
// hand-written burst, reset-abort and interrupt sequences.
module tb_z80_io_master;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [1:0] req_op = 2'd0;
    logic [7:0] req_addr = 8'd0;
    logic [7:0] req_data = 8'd0;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       rsp_intack;
    logic [7:0] addr_bus_out;
    logic [7:0] data_bus_out;
    logic       data_oe;
    logic [7:0] data_bus_in = 8'd0;
    logic       IORQ_L, M1_L, RD_L, WR_L;
    logic       INT_L = 1'b1;
    logic       int_pending;
    logic       busy;

    always #5 clk = ~clk;

    z80_io_master dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_data(req_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_intack(rsp_intack),
        .addr_bus_out(addr_bus_out), .data_bus_out(data_bus_out), .data_oe(data_oe),
        .data_bus_in(data_bus_in),
        .IORQ_L(IORQ_L), .M1_L(M1_L), .RD_L(RD_L), .WR_L(WR_L),
        .INT_L(INT_L), .int_pending(int_pending), .busy(busy)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Bus monitor: strobe-ordering violations, responses, and IORQ_L falling events.
    typedef struct {
        int         kind;  // 0 write, 1 read, 2 intack
        logic [7:0] addr;
        logic [7:0] data;
        int         gap;   // all-high IORQ_L cycles before this cycle
    } ev_t;
    ev_t  evq[$];
    int   viol = 0;
    int   rsp_count = 0;
    int   intack_count = 0;
    int   high_run = 100;
    logic iorq_prev = 1'b1;

    always @(negedge clk) begin
        ev_t ev;
        if (!RD_L && !WR_L) viol++;
        if (!M1_L && (!RD_L || !WR_L)) viol++;
        if (rsp_valid) begin
            rsp_count++;
            if (rsp_intack) intack_count++;
        end
        if (!IORQ_L && iorq_prev) begin
            ev.kind = !M1_L ? 2 : (!WR_L ? 0 : 1);
            ev.addr = addr_bus_out;
            ev.data = data_bus_out;
            ev.gap  = high_run;
            evq.push_back(ev);
        end
        if (IORQ_L) high_run++;
        else        high_run = 0;
        iorq_prev = IORQ_L;
    end

    typedef struct {
        logic [1:0]  op;
        logic [7:0]  addr;
        logic [7:0]  wdata;
        logic [7:0]  bus_in;
        logic [11:0] e_iorq, e_m1, e_rd, e_wr, e_oe, e_rsp, e_busy;
        logic [7:0]  e_rdata;
        logic        e_intack;
    } vec_t;

    vec_t vecs[6];

    initial begin
        logic [11:0] m_iorq, m_m1, m_rd, m_wr, m_oe, m_rsp, m_busy;
        logic [7:0]  got_data, a4, d4;
        logic        got_int, acc;
        int          snap, nready;

        // Bit c of each mask = condition seen in cycle c after the request cycle 0.
        vecs[0] = '{2'd0, 8'hBE, 8'h5A, 8'h00, 12'h038, 12'h000, 12'h000, 12'h038,
                    12'h03C, 12'h000, 12'h0FE, 8'h00, 1'b0};
        vecs[1] = '{2'd1, 8'hBF, 8'h00, 8'hA3, 12'h038, 12'h000, 12'h038, 12'h000,
                    12'h000, 12'h040, 12'h0FE, 8'hA3, 1'b0};
        vecs[2] = '{2'd2, 8'h00, 8'h00, 8'hFF, 12'h038, 12'h03C, 12'h000, 12'h000,
                    12'h000, 12'h040, 12'h0FE, 8'hFF, 1'b1};
        vecs[3] = '{2'd3, 8'hBE, 8'h12, 8'h00, 12'h000, 12'h000, 12'h000, 12'h000,
                    12'h000, 12'h000, 12'h002, 8'h00, 1'b0};
        vecs[4] = '{2'd0, 8'hBF, 8'h81, 8'h00, 12'h038, 12'h000, 12'h000, 12'h038,
                    12'h03C, 12'h000, 12'h0FE, 8'h00, 1'b0};
        vecs[5] = '{2'd1, 8'hBE, 8'h00, 8'h3C, 12'h038, 12'h000, 12'h038, 12'h000,
                    12'h000, 12'h040, 12'h0FE, 8'h3C, 1'b0};

        // Reset values
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check("reset_ctrl",
              {IORQ_L, M1_L, RD_L, WR_L, data_oe, rsp_valid, rsp_intack, int_pending,
               busy, req_ready}, 10'b1111_000001);
        check("reset_addr", addr_bus_out, 8'h00);
        check("reset_dout", data_bus_out, 8'h00);
        check("reset_rsp_data", rsp_data, 8'h00);

        // Table-driven single transactions
        for (int v = 0; v < 6; v++) begin
            m_iorq = '0; m_m1 = '0; m_rd = '0; m_wr = '0; m_oe = '0; m_rsp = '0; m_busy = '0;
            got_data = 8'h00; got_int = 1'b0; a4 = 8'h00; d4 = 8'h00;
            data_bus_in = vecs[v].bus_in;
            req_op      = vecs[v].op;
            req_addr    = vecs[v].addr;
            req_data    = vecs[v].wdata;
            req_valid   = 1'b1;
            for (int c = 0; c < 12; c++) begin
                if (!IORQ_L) m_iorq[c] = 1'b1;
                if (!M1_L)   m_m1[c]   = 1'b1;
                if (!RD_L)   m_rd[c]   = 1'b1;
                if (!WR_L)   m_wr[c]   = 1'b1;
                if (data_oe) m_oe[c]   = 1'b1;
                if (busy)    m_busy[c] = 1'b1;
                if (rsp_valid) begin
                    m_rsp[c] = 1'b1;
                    got_data = rsp_data;
                    got_int  = rsp_intack;
                end
                if (c == 4) begin
                    a4 = addr_bus_out;
                    d4 = data_bus_out;
                end
                tick();
                req_valid = 1'b0;
            end
            check($sformatf("v%0d_iorq", v), m_iorq, vecs[v].e_iorq);
            check($sformatf("v%0d_m1", v),   m_m1,   vecs[v].e_m1);
            check($sformatf("v%0d_rd", v),   m_rd,   vecs[v].e_rd);
            check($sformatf("v%0d_wr", v),   m_wr,   vecs[v].e_wr);
            check($sformatf("v%0d_oe", v),   m_oe,   vecs[v].e_oe);
            check($sformatf("v%0d_rsp", v),  m_rsp,  vecs[v].e_rsp);
            check($sformatf("v%0d_busy", v), m_busy, vecs[v].e_busy);
            if (vecs[v].e_rsp != 12'h000) begin
                check($sformatf("v%0d_rdata", v),  got_data, vecs[v].e_rdata);
                check($sformatf("v%0d_intack", v), got_int,  vecs[v].e_intack);
            end
            if (vecs[v].op != 2'd3) check($sformatf("v%0d_addr", v), a4, vecs[v].addr);
            if (vecs[v].op == 2'd0) check($sformatf("v%0d_dout", v), d4, vecs[v].wdata);
            tick();
            tick();
        end

        // Burst: one blocking write, then 5 writes into a 4-deep FIFO
        evq.delete();
        req_op = 2'd0; req_addr = 8'h10; req_data = 8'h11; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            req_addr  = 8'h20 + 8'(i);
            req_data  = 8'hA0 + 8'(i);
            req_valid = 1'b1;
            acc = 1'b0;
            nready = 0;
            for (int w = 0; w < 40 && !acc; w++) begin
                acc = req_ready;
                if (!req_ready) nready++;
                tick();
            end
            req_valid = 1'b0;
            check($sformatf("burst_accept%0d", i), acc, 1'b1);
            if (i == 3) check("burst_ready_full", req_ready, 1'b0);
            if (i == 4) check("burst_held_cycles", nready, 3);
        end
        repeat (60) tick();
        check("burst_count", evq.size(), 6);
        for (int k = 0; k < evq.size() && k < 6; k++) begin
            check($sformatf("burst_kind%0d", k), evq[k].kind, 0);
            check($sformatf("burst_addr%0d", k), evq[k].addr, (k == 0) ? 8'h10 : 8'h20 + 8'(k - 1));
            check($sformatf("burst_data%0d", k), evq[k].data, (k == 0) ? 8'h11 : 8'hA0 + 8'(k - 1));
            if (k > 0) check($sformatf("burst_gap%0d", k), evq[k].gap, 4);
        end

        // Reset during the 2nd T2 cycle of a read
        snap = rsp_count;
        data_bus_in = 8'h55;
        req_op = 2'd1; req_addr = 8'hBF; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        repeat (3) tick();
        check("abort_rd_low", RD_L, 1'b0);
        rst = 1'b1;
        tick();
        check("abort_strobes", {IORQ_L, M1_L, RD_L, WR_L}, 4'hF);
        check("abort_oe", data_oe, 1'b0);
        check("abort_busy", busy, 1'b0);
        check("abort_ready", req_ready, 1'b1);
        rst = 1'b0;
        repeat (10) tick();
        check("abort_no_rsp", rsp_count - snap, 0);

`ifdef Z80IO_AUTO_INTACK_EN
        // INT_L low with a queued write: intack first, exactly once
        evq.delete();
        snap = intack_count;
        data_bus_in = 8'hC7;
        req_op = 2'd0; req_addr = 8'hBE; req_data = 8'h77; req_valid = 1'b1;
        INT_L = 1'b0;
        tick();
        req_valid = 1'b0;
        repeat (20) tick();
        INT_L = 1'b1;
        repeat (15) tick();
        check("auto_events", evq.size(), 2);
        if (evq.size() >= 2) begin
            check("auto_first_intack", evq[0].kind, 2);
            check("auto_then_write", evq[1].kind, 0);
            check("auto_write_data", evq[1].data, 8'h77);
        end
        check("auto_single_ack", intack_count - snap, 1);
`else
        // INT_L is only reported, never acknowledged on its own
        snap = rsp_count;
        INT_L = 1'b0;
        tick();
        tick();
        check("int_pending_set", int_pending, 1'b1);
        repeat (10) tick();
        check("int_no_auto_rsp", rsp_count - snap, 0);
        INT_L = 1'b1;
        tick();
        tick();
        check("int_pending_clr", int_pending, 1'b0);
`endif

        check("strobe_invariants", viol, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/z80_io_master.md
Name: z80_io_master

Overview:
- Z80-side bus initiator for the VDP I/O interface, used as the CPU stand-in for board bring-up and VDP verification.
- Takes queued requests (port write, port read, interrupt acknowledge) and drives Z80-style I/O cycles on IORQ_L/M1_L/RD_L/WR_L/addr/data.
- Holds strobes long enough for the VDP port decoder's two-cycle WR0/WR1 and RD0/RD1 sequences, then returns read data and interrupt vectors.

Parameters:
- DEPTH, 4: request FIFO entries; must be a power of 2, ≥2.
- STROBE_CYCLES, 3: cycles IORQ_L and RD_L/WR_L (or M1_L and IORQ_L) stay low; legal range 2..15.
- RECOVERY_CYCLES, 1: idle cycles with all strobes high between bus cycles; legal range 0..7.

Ports:
- clk  in  1  sole clock; all logic on posedge.
- rst  in  1  synchronous reset, active high.
- req_valid  in  1  request present.
- req_ready  out  1  FIFO not full.
- req_op  in  2  0=write, 1=read, 2=intack, 3=reserved (accepted, then dropped without a bus cycle).
- req_addr  in  8  I/O port number; 8'hBE is the data port, 8'hBF is the control port.
- req_data  in  8  write data.
- rsp_valid  out  1  one-cycle pulse carrying read data or the interrupt vector.
- rsp_data  out  8  data sampled from the bus.
- rsp_intack  out  1  qualifies rsp_valid: 1 means the response is an intack vector.
- addr_bus_out  out  8  port address.
- data_bus_out  out  8  write data.
- data_oe  out  1  master is driving the data bus.
- data_bus_in  in  8  read data / vector from the bus.
- IORQ_L, M1_L, RD_L, WR_L  out  1 each  Z80 strobes, active low.
- INT_L  in  1  VDP interrupt request, active low.
- int_pending  out  1  registered copy of ~INT_L.
- busy  out  1  FSM not in IDLE, or FIFO not empty.

Behaviour:
- Reset (sync, rst=1): FIFO emptied; FSM to IDLE.
  - Reset output values: IORQ_L, M1_L, RD_L, WR_L = 1; addr_bus_out = 0; data_bus_out = 0; data_oe = 0; rsp_valid = 0; rsp_data = 0; rsp_intack = 0; int_pending = 0; busy = 0; req_ready = 1.
  - Reset mid-cycle aborts immediately. Strobes are high in the cycle after the reset edge. No response is issued.
- FIFO:
  - Push on req_valid & req_ready. Pop only from IDLE.
  - Push while full is impossible because req_ready=0. Push and pop in the same cycle are both honoured.
  - Pointers are log2(DEPTH)+1 bits wide and wrap modulo 2*DEPTH.
- FSM states: IDLE, T1, T2, T3, REC, INTA1, INTA2. All outputs are registered.
- IDLE:
  - FIFO non-empty → pop the head.
  - op 0/1 → T1. op 2 → INTA1. op 3 → stay in IDLE (entry discarded).
- Latency: request accepted in cycle N → entry visible in cycle N+1 → first bus cycle (T1/INTA1) is cycle N+2.
- T1 (1 cycle):
  - addr_bus_out = req_addr; all strobes high.
  - Write: data_bus_out = req_data, data_oe = 1.
- T2 (STROBE_CYCLES cycles, down-counter):
  - IORQ_L = 0, plus WR_L = 0 (write) or RD_L = 0 (read).
  - addr and data held.
  - Read: data_bus_in is captured at the edge ending the last T2 cycle.
- T3 (1 cycle):
  - Strobes high; addr held; data_oe dropped.
  - Read: rsp_valid = 1 with the captured data, rsp_intack = 0.
- REC: RECOVERY_CYCLES cycles, then IDLE. When RECOVERY_CYCLES = 0, T3 goes directly to IDLE.
- INTA1 (1 cycle): M1_L = 0; IORQ_L = 1; data_oe = 0.
- INTA2 (STROBE_CYCLES cycles): M1_L = 0 and IORQ_L = 0; data_bus_in captured at the last edge; then T3 with rsp_intack = 1.
- Strobe ordering invariants:
  - RD_L and WR_L are never low together.
  - M1_L is never low together with RD_L or WR_L.
  - addr is stable from T1 through T3.
- rsp_valid has no backpressure.
- int_pending tracks INT_L with 1 cycle of delay and never gates explicit requests.

Optional Feature:
- Macro: Z80IO_AUTO_INTACK_EN.
- Defined:
  - In IDLE, int_pending = 1 takes priority over the FIFO head and starts INTA1 → INTA2 → T3 without consuming a FIFO entry. The response carries rsp_intack = 1.
  - After an auto intack, another auto intack is suppressed until int_pending has been 0 for at least 1 cycle. This prevents re-ack while the VDP is still clearing INT_L.
- Undefined: interrupts are acknowledged only by an explicit op 2. int_pending is informational only.

Test Plan:
- Write op0, addr BE, data 5A at cycle 0:
  - addr_bus_out = BE from cycle 2; IORQ_L and WR_L low in cycles 3–5, RD_L high throughout.
  - data_oe = 1 in cycles 2–5; no rsp_valid.
- Read op1, addr BF, data_bus_in = A3 during T2 → rsp_valid pulses once in cycle 6 with rsp_data = A3 and rsp_intack = 0.
- Burst of 5 writes with DEPTH = 4 while blocked:
  - req_ready falls after the 4th accept; 5th request is held off.
  - All 5 bus cycles occur in order, with exactly 1 all-high REC cycle between consecutive cycles.
- Explicit intack op2 with data_bus_in = FF:
  - M1_L low for 4 cycles; IORQ_L low only for the last 3 of them.
  - rsp_valid with rsp_intack = 1 and rsp_data = FF.
- rst pulse in the 2nd T2 cycle of a read:
  - Next cycle: all strobes 1, data_oe = 0, FIFO empty, busy = 0.
  - No rsp_valid is ever issued for the aborted read.
- Z80IO_AUTO_INTACK_EN defined, INT_L driven low while a write is queued:
  - Intack cycle runs first, then the write.
  - INT_L held low for 20 more cycles still produces exactly one intack.
